serial_add_ctrl: RTL and testbench

//  Bit-serial adder controller: one FullAdder instance is time-shared over the

---
 rtl/serial_add_ctrl_pkg.sv | 12 +
 rtl/serial_add_ctrl_fulladder.sv | 16 +
 rtl/serial_add_ctrl.sv | 115 +++++++++++
 tb/tb_serial_add_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_t : FSM state encoding (IDLE/RUN/FIN); any other code is illegal
//             and recovers to IDLE.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_fulladder.sv
// Single-bit full adder, the only datapath element of the serial adder.
//   A, B, CIN : operand bits and carry-in
//   SUM       : A ^ B ^ CIN
//   CARRY     : majority(A, B, CIN)
module FullAdder (
  input  logic A,
  input  logic B,
  input  logic CIN,
  output logic SUM,
  output logic CARRY
);

  assign SUM   = A ^ B ^ CIN;
  assign CARRY = (A & B) | (A & CIN) | (B & CIN);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one FullAdder is time-shared over WIDTH bits,
// LSB first, one bit per clock, with a START/BUSY/DONE handshake.
//   CLK, RST_N   : clock, synchronous active-low reset
//   START        : request, honoured only in IDLE
//   A, B, CIN    : operands and carry-in, captured when START is accepted
//   BUSY         : high while an operation is in RUN or FIN
//   DONE         : one-cycle pulse when SUM/COUT/OVF are updated
//   SUM/COUT/OVF : registered result, carry-out and signed overflow
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_s_sr;
  logic             r_c;      // running carry
  logic             r_c_msb;  // carry into the MSB, for overflow
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic w_fa_sum;
  logic w_fa_carry;

  FullAdder u_fa (
    .A     (r_a_sr[0]),
    .B     (r_b_sr[0]),
    .CIN   (r_c),
    .SUM   (w_fa_sum),
    .CARRY (w_fa_carry)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_c     <= 1'b0;
      r_c_msb <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_a_sr  <= A;
            r_b_sr  <= B;
            r_c     <= CIN;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Sum bits enter at the top so the LSB ends up at bit 0 after WIDTH shifts.
          r_s_sr <= {w_fa_sum, r_s_sr[WIDTH-1:1]};
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_c    <= w_fa_carry;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_c_msb <= r_c;
            r_state <= ST_FIN;
          end
        end
        ST_FIN: begin
          r_sum   <= r_s_sr;
          r_cout  <= r_c;
          r_ovf   <= r_c_msb ^ r_c;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY = r_busy;
  assign DONE = r_done;
  assign SUM  = r_sum;
  assign COUT = r_cout;
  assign OVF  = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         START = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         CIN = 1'b0;
  logic         BUSY, DONE, COUT, OVF;
  logic [W-1:0] SUM;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B), .CIN(CIN),
    .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .COUT(COUT), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an op accepted at an edge completes WIDTH+1 edges later;
  // the result is plain integer arithmetic on the captured operands.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;
  logic [W-1:0] p_sum;
  logic         p_cout, p_ovf;

  function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c, output logic [W-1:0] s,
                                  output logic co, output logic ov);
    longint ua, ub, sa, sb, tot, st;
    ua = longint'(a); ub = longint'(b);
    sa = a[W-1] ? ua - (64'sd1 <<< W) : ua;
    sb = b[W-1] ? ub - (64'sd1 <<< W) : ub;
    tot = ua + ub + longint'(c);
    st  = sa + sb + longint'(c);
    s  = W'(tot);
    co = tot >= (64'sd1 <<< W);
    ov = (st > ((64'sd1 <<< (W-1)) - 1)) || (st < -(64'sd1 <<< (W-1)));
  endfunction

  always @(posedge CLK) begin
    if (!RST_N) begin
      m_left = 0; m_done = 0; m_sum = '0; m_cout = 0; m_ovf = 0;
    end else begin
      m_done = 0;
      if (m_left == 0) begin
        if (START) begin
          ref_add(A, B, CIN, p_sum, p_cout, p_ovf);
          m_left = W + 1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf; m_done = 1;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("cyc_done", DONE, m_done);
      check("cyc_busy", BUSY, m_left != 0);
      check("cyc_sum",  SUM,  m_sum);
      check("cyc_cout", COUT, m_cout);
      check("cyc_ovf",  OVF,  m_ovf);
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(negedge CLK);
    A = a; B = b; CIN = c; START = 1'b1;
  endtask

  // Counts falling edges until DONE is seen; optionally drops START after the first.
  task automatic wait_done(input bit drop_start, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (drop_start && i == 1) START = 1'b0;
      if (DONE === 1'b1) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) check("done_timeout", 0, 1);
  endtask

  task automatic count_dones(input int ncyc, output int nd);
    nd = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) nd++;
    end
  endtask

  task automatic op_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W-1:0] es, input logic eco,
                        input logic eov);
    int cyc;
    issue(a, b, c);
    wait_done(1'b1, cyc);
    check({name, "_lat"},  cyc, 10);
    check({name, "_sum"},  SUM, es);
    check({name, "_cout"}, COUT, eco);
    check({name, "_ovf"},  OVF, eov);
  endtask

  initial begin
    int cyc, nd;
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   tot;

    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    chk_en = 1'b1;
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_sum",  SUM, 0);
    check("rst_cout", COUT, 0);

    // Directed literal vectors
    op_lit("t1", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    op_lit("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op_lit("t2b", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    op_lit("negmax", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    op_lit("allone", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // START held: back-to-back ops, operand change mid-RUN ignored by current op
    issue(8'h01, 8'h02, 1'b0);
    repeat (3) @(negedge CLK);
    A = 8'h10;
    wait_done(1'b0, cyc);
    check("held_sum1", SUM, 8'h03);
    wait_done(1'b0, cyc);
    START = 1'b0;
    check("held_period", cyc, 10);
    check("held_sum2", SUM, 8'h12);
    repeat (2) @(negedge CLK);

    // START during RUN is ignored
    issue(8'h11, 8'h22, 1'b0);
    @(negedge CLK); START = 1'b0;
    repeat (2) @(negedge CLK);
    A = 8'hFF; B = 8'hFF; START = 1'b1;
    @(negedge CLK); START = 1'b0;
    wait_done(1'b0, cyc);
    check("ign_sum", SUM, 8'h33);
    count_dones(14, nd);
    check("ign_extra_done", nd, 0);

    // Reset in the middle of RUN aborts the op
    issue(8'h0F, 8'h01, 1'b0);
    @(negedge CLK); START = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    check("abort_busy", BUSY, 0);
    check("abort_sum",  SUM, 0);
    check("abort_done", DONE, 0);
    count_dones(14, nd);
    check("abort_no_done", nd, 0);
    op_lit("fresh", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    // Random ops; operands wiggle while busy to show capture-at-accept
    for (int k = 0; k < 1000; k++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      issue(ra, rb, rc);
      @(negedge CLK);
      START = 1'b0;
      A = W'($urandom); B = W'($urandom); CIN = 1'($urandom);
      wait_done(1'b0, cyc);
      tot = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      check("rnd_sum_cout", {COUT, SUM}, tot);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge CLK);
    end

    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
